// File: rtl/operand_forward_source_pkg.sv
// rtl/operand_forward_source_pkg.sv - shared widths and stage entry type for the operand forward source
package operand_forward_source_pkg;

  localparam int DATA_W = 16;
  localparam int NREG   = 8;
  localparam int AW     = 3;

  typedef struct packed {
    logic              v;
    logic [AW-1:0]     dest;
    logic [DATA_W-1:0] data;
    logic              is_load;
  } fwd_entry_t;

endpackage

// File: rtl/operand_forward_source_fwd_match.sv
// rtl/operand_forward_source_fwd_match.sv - compares one in-flight entry against the stage-2 source index
module fwd_match
  import operand_forward_source_pkg::*;
(
  input  fwd_entry_t        i_entry,
  input  logic [AW-1:0]     i_sel,
  output logic              o_hit,
  output logic              o_is_load,
  output logic [DATA_W-1:0] o_data
);

  assign o_hit     = i_entry.v & (i_entry.dest == i_sel);
  assign o_is_load = i_entry.is_load;
  assign o_data    = i_entry.data;

endmodule

// File: rtl/operand_forward_source.sv
// rtl/operand_forward_source.sv - stage-4 entry, register-file commit and operand forwarding; FWD_STATS_EN adds hit/stall counters
module operand_forward_source
  import operand_forward_source_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              Hold,
  input  logic              ExValid,
  input  logic [AW-1:0]     ExDest,
  input  logic [DATA_W-1:0] ExData,
  input  logic              ExIsLoad,
  input  logic [DATA_W-1:0] MemData,
  input  logic              SrcUse,
  input  logic [AW-1:0]     SrcSel,
  output logic [DATA_W-1:0] OF,
  output logic              FLRN,
  output logic              Stall,
  output logic              RfWe,
  output logic [AW-1:0]     RfWaddr,
  output logic [DATA_W-1:0] RfWdata,
`ifdef FWD_STATS_EN
  output logic [15:0]       FwdHits,
  output logic [15:0]       StallCnt,
`endif
  output logic [NREG-1:0]   Pending
);

  fwd_entry_t        r_s4;
  fwd_entry_t        w_s3;
  fwd_entry_t        w_s4;
  logic              w_s3_hit, w_s3_ld;
  logic              w_s4_hit, w_s4_ld;
  logic [DATA_W-1:0] w_s3_data, w_s4_data;

  assign w_s3 = '{v: ExValid, dest: ExDest, data: ExData, is_load: ExIsLoad};

  always_ff @(posedge clk) begin
    if (rst)
      r_s4 <= '0;
    else if (!Hold)
      r_s4 <= w_s3;
  end

  // The stage-4 entry is masked during reset so nothing stale can commit or forward.
  assign w_s4 = rst ? '0 : r_s4;

  fwd_match u_match_s3 (
    .i_entry   (w_s3),
    .i_sel     (SrcSel),
    .o_hit     (w_s3_hit),
    .o_is_load (w_s3_ld),
    .o_data    (w_s3_data)
  );

  fwd_match u_match_s4 (
    .i_entry   (w_s4),
    .i_sel     (SrcSel),
    .o_hit     (w_s4_hit),
    .o_is_load (w_s4_ld),
    .o_data    (w_s4_data)
  );

  assign RfWe    = w_s4.v & !Hold;
  assign RfWaddr = w_s4.dest;
  assign RfWdata = w_s4.is_load ? MemData : w_s4.data;

  // Youngest producer wins; a stage-3 load cannot supply data yet, so it stalls.
  always_comb begin
    OF    = '0;
    FLRN  = 1'b0;
    Stall = 1'b0;
    if (SrcUse) begin
      if (w_s3_hit) begin
        if (w_s3_ld) begin
          Stall = 1'b1;
        end else begin
          FLRN = 1'b1;
          OF   = w_s3_data;
        end
      end else if (w_s4_hit) begin
        FLRN = 1'b1;
        OF   = w_s4_ld ? MemData : w_s4_data;
      end
    end
  end

  always_comb begin
    Pending = '0;
    for (int r = 0; r < NREG; r++)
      Pending[r] = (w_s3.v & (w_s3.dest == AW'(r))) | (w_s4.v & (w_s4.dest == AW'(r)));
  end

`ifdef FWD_STATS_EN
  logic [15:0] r_fwd_hits;
  logic [15:0] r_stall_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_fwd_hits  <= '0;
      r_stall_cnt <= '0;
    end else begin
      if (FLRN && r_fwd_hits != 16'hFFFF)
        r_fwd_hits <= r_fwd_hits + 16'd1;
      if (Stall && !Hold && r_stall_cnt != 16'hFFFF)
        r_stall_cnt <= r_stall_cnt + 16'd1;
    end
  end

  assign FwdHits  = r_fwd_hits;
  assign StallCnt = r_stall_cnt;
`endif

endmodule

// File: tb/tb_operand_forward_source.sv
// tb/tb_operand_forward_source.sv - directed self-checking bench for operand_forward_source
module tb_operand_forward_source;
  import operand_forward_source_pkg::*;

  logic              clk = 1'b0;
  logic              rst, Hold, ExValid, ExIsLoad, SrcUse;
  logic [AW-1:0]     ExDest, SrcSel;
  logic [DATA_W-1:0] ExData, MemData;
  logic [DATA_W-1:0] OF, RfWdata;
  logic              FLRN, Stall, RfWe;
  logic [AW-1:0]     RfWaddr;
  logic [NREG-1:0]   Pending;
`ifdef FWD_STATS_EN
  logic [15:0]       FwdHits, StallCnt;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  operand_forward_source dut (
    .clk      (clk),
    .rst      (rst),
    .Hold     (Hold),
    .ExValid  (ExValid),
    .ExDest   (ExDest),
    .ExData   (ExData),
    .ExIsLoad (ExIsLoad),
    .MemData  (MemData),
    .SrcUse   (SrcUse),
    .SrcSel   (SrcSel),
    .OF       (OF),
    .FLRN     (FLRN),
    .Stall    (Stall),
    .RfWe     (RfWe),
    .RfWaddr  (RfWaddr),
    .RfWdata  (RfWdata),
`ifdef FWD_STATS_EN
    .FwdHits  (FwdHits),
    .StallCnt (StallCnt),
`endif
    .Pending  (Pending)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic ex(input logic v, input logic [AW-1:0] d, input logic [DATA_W-1:0] x, input logic ld);
    ExValid  = v;
    ExDest   = d;
    ExData   = x;
    ExIsLoad = ld;
  endtask

  initial begin
    rst = 1'b1; Hold = 1'b0; SrcUse = 1'b0; SrcSel = '0; MemData = '0;
    ex(1'b1, 3'd1, 16'h0055, 1'b0);

    // reset held two cycles with a live stage-3 result
    @(negedge clk);
    chk("rst_we0", RfWe, 0);
    chk("rst_pend_ex", Pending, 8'h02);
    next_cycle();
    @(negedge clk);
    chk("rst_we1", RfWe, 0);
    chk("rst_flrn", FLRN, 0);
    next_cycle();
    rst = 1'b0;
    ex(1'b0, 3'd0, 16'h0000, 1'b0);
    @(negedge clk);
    chk("post_rst_we", RfWe, 0);
    chk("post_rst_pend", Pending, 8'h00);
    chk("post_rst_of", OF, 0);
    chk("post_rst_waddr", RfWaddr, 0);
    chk("post_rst_wdata", RfWdata, 0);
    next_cycle();

    // ALU forward from stage 3, then from stage 4
    SrcUse = 1'b1; SrcSel = 3'd3;
    ex(1'b1, 3'd3, 16'h1234, 1'b0);
    @(negedge clk);
    chk("alu_s3_flrn", FLRN, 1);
    chk("alu_s3_of", OF, 16'h1234);
    chk("alu_s3_stall", Stall, 0);
    chk("alu_s3_pend", Pending, 8'h08);
    chk("alu_s3_we", RfWe, 0);
    next_cycle();
    ex(1'b0, 3'd0, 16'h0000, 1'b0);
    @(negedge clk);
    chk("alu_s4_flrn", FLRN, 1);
    chk("alu_s4_of", OF, 16'h1234);
    chk("alu_s4_we", RfWe, 1);
    chk("alu_s4_waddr", RfWaddr, 3);
    chk("alu_s4_wdata", RfWdata, 16'h1234);
    next_cycle();

    // load-use stall then forward of memory data
    SrcSel = 3'd5;
    ex(1'b1, 3'd5, 16'hDEAD, 1'b1);
    @(negedge clk);
    chk("ld_stall", Stall, 1);
    chk("ld_flrn", FLRN, 0);
    chk("ld_of", OF, 0);
    chk("ld_we", RfWe, 0);
    next_cycle();
    ex(1'b0, 3'd0, 16'h0000, 1'b0);
    MemData = 16'hBEEF;
    @(negedge clk);
    chk("ld_s4_stall", Stall, 0);
    chk("ld_s4_flrn", FLRN, 1);
    chk("ld_s4_of", OF, 16'hBEEF);
    chk("ld_s4_wdata", RfWdata, 16'hBEEF);
    chk("ld_s4_waddr", RfWaddr, 5);
    chk("ld_s4_we", RfWe, 1);
    next_cycle();
    MemData = 16'h0000;

`ifdef FWD_STATS_EN
    chk("stall_cnt", StallCnt, 1);
`endif

    // stage 3 beats stage 4 on the same register
    SrcSel = 3'd2;
    ex(1'b1, 3'd2, 16'h0001, 1'b0);
    @(negedge clk);
    chk("pri_first_of", OF, 16'h0001);
    next_cycle();
    ex(1'b1, 3'd2, 16'h0002, 1'b0);
    @(negedge clk);
    chk("pri_of", OF, 16'h0002);
    chk("pri_we", RfWe, 1);
    chk("pri_wdata_old", RfWdata, 16'h0001);
    next_cycle();
    ex(1'b0, 3'd0, 16'h0000, 1'b0);
    @(negedge clk);
    chk("pri_wdata_new", RfWdata, 16'h0002);
    chk("pri_of_s4", OF, 16'h0002);
    next_cycle();

    // SrcUse=0 suppresses forwarding
    SrcUse = 1'b0; SrcSel = 3'd6;
    ex(1'b1, 3'd6, 16'h0AAA, 1'b0);
    @(negedge clk);
    chk("nouse_flrn", FLRN, 0);
    chk("nouse_of", OF, 0);
    next_cycle();

    // Hold for three cycles with a valid stage-4 entry
    SrcUse = 1'b1; SrcSel = 3'd7;
    ex(1'b1, 3'd4, 16'h4444, 1'b0);
    @(negedge clk);
    chk("pre_hold_waddr", RfWaddr, 6);
    chk("pre_hold_we", RfWe, 1);
    next_cycle();
    Hold = 1'b1; SrcSel = 3'd4;
    for (int i = 0; i < 3; i++) begin
      if (i == 1) begin
        ex(1'b1, 3'd1, 16'h0000, 1'b1);
        SrcSel = 3'd1;
      end else begin
        ex(1'b0, 3'd0, 16'h0000, 1'b0);
        SrcSel = 3'd4;
      end
      @(negedge clk);
      chk($sformatf("hold_we_%0d", i), RfWe, 0);
      chk($sformatf("hold_waddr_%0d", i), RfWaddr, 4);
      chk($sformatf("hold_pend_%0d", i), Pending, (i == 1) ? 8'h12 : 8'h10);
      if (i == 1) chk("hold_stall", Stall, 1);
      else        chk("hold_of", OF, 16'h4444);
      next_cycle();
    end
    Hold = 1'b0;
    ex(1'b0, 3'd0, 16'h0000, 1'b0);
    @(negedge clk);
    chk("rel_we", RfWe, 1);
    chk("rel_wdata", RfWdata, 16'h4444);
    next_cycle();
    @(negedge clk);
    chk("rel_once_we", RfWe, 0);
    chk("rel_pend", Pending, 8'h00);
    next_cycle();

    // R0 forwards like any register
    SrcSel = 3'd0;
    ex(1'b1, 3'd0, 16'h0F0F, 1'b0);
    @(negedge clk);
    chk("r0_flrn", FLRN, 1);
    chk("r0_of", OF, 16'h0F0F);
    next_cycle();

    // reset mid-flight drops the R0 entry
    rst = 1'b1;
    ex(1'b0, 3'd0, 16'h0000, 1'b0);
    @(negedge clk);
    chk("midrst_we", RfWe, 0);
    chk("midrst_flrn", FLRN, 0);
    next_cycle();
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_after_we", RfWe, 0);
    chk("midrst_after_pend", Pending, 8'h00);
    next_cycle();

`ifdef FWD_STATS_EN
    SrcSel = 3'd3;
    ex(1'b1, 3'd3, 16'h0033, 1'b0);
    for (int i = 0; i < 70000; i++) next_cycle();
    @(negedge clk);
    chk("hits_sat", FwdHits, 16'hFFFF);
    next_cycle();
    rst = 1'b1;
    next_cycle();
    rst = 1'b0;
    ex(1'b0, 3'd0, 16'h0000, 1'b0);
    @(negedge clk);
    chk("hits_clr", FwdHits, 16'h0000);
    chk("stall_clr", StallCnt, 16'h0000);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/operand_forward_source.md
Name: operand_forward_source

Overview:
- Producer end of the stage-2 operand-forwarding path in the pipelined RISC core.
- Takes results leaving stage 3 (execute) and holds them as the stage-4 (memory/write-back) entry.
- Drives the forwarded operand value, the forward-valid flag and the load-use stall back to the stage-2 operand mux.
- Issues the register-file write at the end of stage 4.

Parameters:
- DATA_W, 16, operand/result width.
- NREG, 8, number of architectural registers (R0..R7).
- AW, 3, register index width; must equal clog2(NREG).

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  reset, synchronous, active-high.
- Hold  in  1  pipeline freeze; stage-4 entry is held and no commit occurs.
- ExValid  in  1  stage-3 result present this cycle.
- ExDest  in  AW  destination register of the stage-3 result.
- ExData  in  DATA_W  ALU result; ignored when ExIsLoad=1.
- ExIsLoad  in  1  stage-3 instruction is a load; data arrives in stage 4.
- MemData  in  DATA_W  load data, valid while the stage-4 entry is a load.
- SrcUse  in  1  stage 2 is reading a register operand this cycle.
- SrcSel  in  AW  register index being read by stage 2 (RN or R0).
- OF  out  DATA_W  forwarded operand value.
- FLRN  out  1  OF is valid and must override the register-file value.
- Stall  out  1  load-use hazard; stage 2 must not advance.
- RfWe  out  1  register-file write enable.
- RfWaddr  out  AW  register-file write address.
- RfWdata  out  DATA_W  register-file write data.
- Pending  out  NREG  bit r set while any in-flight result targets register r.

Behaviour:
- State: S4 entry {V, Dest, Data, IsLoad}.
  - Reset clears V, IsLoad, Dest and Data to 0. Reset mid-operation drops the in-flight entry; no commit occurs.
- Load rule, on every edge with rst=0:
  - Hold=0: S4 <= {ExValid, ExDest, ExData, ExIsLoad}.
  - Hold=1: S4 keeps its value.
- Commit (combinational from S4):
  - RfWe = S4.V & !Hold & !rst; RfWaddr = S4.Dest.
  - RfWdata = S4.IsLoad ? MemData : S4.Data.
  - The register file writes at the same edge.
  - Latency: result presented at cycle t is written at the end of t+1 and is readable from the register file at t+2.
- Forwarding (combinational; SrcUse=0 forces FLRN=0 and Stall=0):
  - Stage-3 hit: ExValid & ExDest==SrcSel.
    - Non-load: FLRN=1, OF=ExData.
    - Load: Stall=1, FLRN=0.
  - Else stage-4 hit: S4.V & S4.Dest==SrcSel. FLRN=1, OF=RfWdata.
  - Else FLRN=0 and OF=0.
  - Stage-3 beats stage-4 when both target the same register (youngest wins).
- Stall is not gated by Hold. The upstream controller owns Hold; Stall only requests a bubble.
- Pending[r] = (ExValid & ExDest==r) | (S4.V & S4.Dest==r).
- R0 is an ordinary forwardable register; there is no hardwired zero.
- All outputs are 0 during rst=1 and in the cycle after reset, unless driven by the current ExValid.

Optional Feature:
- Macro: FWD_STATS_EN.
- When defined, the block adds these outputs:
  - FwdHits (16): saturating count of cycles with FLRN=1.
  - StallCnt (16): saturating count of cycles with Stall=1 & !Hold.
  - Both counters clear on rst and hold at 16'hFFFF.
- When not defined, these ports and counters are absent and behaviour is otherwise identical.

Decomposition:
- Shared package holds:
  - DATA_W, NREG, AW constants.
  - Typedef fwd_entry_t {v, dest, data, is_load}.
- One sub-module, fwd_match: compares one entry against SrcSel and returns {hit, is_load, data}. It is instantiated for stage 3 and stage 4; the top level applies priority.

Test Plan:
- Reset: rst=1 for 2 cycles with ExValid=1 -> RfWe=0, S4 empty, Pending=0 after release.
- ALU forward: ExValid=1, ExDest=3, ExData=16'h1234, SrcSel=3, SrcUse=1 -> FLRN=1, OF=1234 same cycle. Next cycle OF=1234 from S4 and RfWe=1, RfWaddr=3.
- Load-use: ExIsLoad=1, ExDest=5, SrcSel=5 -> Stall=1, FLRN=0. Next cycle MemData=16'hBEEF -> FLRN=1, OF=BEEF, RfWdata=BEEF.
- Priority: S4 holds R2=16'h0001 while Ex has R2=16'h0002, SrcSel=2 -> OF=0002. RfWe writes 0001 this cycle and 0002 the next.
- Hold: Hold=1 for 3 cycles with S4.V=1 -> RfWe=0, S4 unchanged, Pending bit stays set. Release -> exactly one commit.
- FWD_STATS_EN: 70000 cycles of continuous forwarding hits -> FwdHits saturates at FFFF; rst clears it to 0.
